imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_pkg.sv | 24 ++
 rtl/resp_fifo.sv | 49 ++++
 rtl/imem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: defaults, NOP encoding,
// response record layout and the queue pointer-width helper.
package imem_responder_pkg;

  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_QDEPTH  = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] instr;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int ptr_w(input int qdepth);
    return $clog2(qdepth) + 1;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Response queue: FIFO with wrap-bit pointers; a pushed entry is visible at the next edge.
// No internal backpressure: the caller's credit scheme guarantees push never overflows.
module resp_fifo
  import imem_responder_pkg::*;
#(
  parameter int WIDTH  = RSP_W,
  parameter int QDEPTH = DEF_QDEPTH,
  localparam int PW    = ptr_w(QDEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full,
  output logic [PW-1:0]    count
);

  logic [WIDTH-1:0] store [QDEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Push into a full queue with a concurrent pop reuses the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push && !clr) store[wr_ptr[PW-2:0]] <= push_dat;
  end

  assign head_dat = store[rd_ptr[PW-2:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder: LATENCY-cycle memory pipeline into a QDEPTH response queue.
// req_ready is a credit: low once queued + in-flight fetches reach QDEPTH, so nothing is dropped.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int QDEPTH  = DEF_QDEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_pc,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = ptr_w(QDEPTH);

  logic [31:0]        mem [DEPTH];
  logic               prog_hit;
  logic               req_in_range;
  logic               req_err;
  logic [31:0]        rd_word;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full_unused;
  logic               prog_lsb_unused;
  logic [PW-1:0]      q_count;
  logic [PW:0]        occupancy;
  logic [LATENCY-1:0] pipe_vld;
  rsp_t               pipe_rsp [LATENCY];
  rsp_t               acc_rsp;
  rsp_t               head_rsp;

  assign prog_lsb_unused = ^prog_addr[1:0];
  assign prog_hit        = prog_we && ({2'b00, prog_addr[31:2]} < 32'(DEPTH));

  // Instruction storage is deliberately outside reset so a program survives it.
  always_ff @(posedge clk) begin
    if (prog_hit) mem[prog_addr[AW+1:2]] <= prog_data;
  end

  assign req_in_range = {2'b00, req_addr[31:2]} < 32'(DEPTH);
  assign req_err      = (req_addr[1:0] != 2'b00) || !req_in_range;
  assign rd_word      = (prog_hit && (prog_addr[31:2] == req_addr[31:2])) ? prog_data
                                                                          : mem[req_addr[AW+1:2]];

  always_comb begin
    acc_rsp.err   = req_err;
    acc_rsp.pc    = req_addr;
    acc_rsp.instr = req_err ? NOP_INSTR : rd_word;
  end

  always_comb begin
    occupancy = {1'b0, q_count};
    for (int i = 0; i < LATENCY; i++) begin
      occupancy = occupancy + {{PW{1'b0}}, pipe_vld[i]};
    end
  end

  assign req_ready = !rst && !flush && (occupancy < (PW+1)'(QDEPTH));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
    end else if (flush) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_rsp[0] <= acc_rsp;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_rsp[i] <= pipe_rsp[i-1];
    end
  end

  assign push = pipe_vld[LATENCY-1] && !flush;
  assign pop  = rsp_valid && rsp_ready && !flush;

  resp_fifo #(
    .WIDTH  (RSP_W),
    .QDEPTH (QDEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push     (push),
    .push_dat (pipe_rsp[LATENCY-1]),
    .pop      (pop),
    .head_dat (head_rsp),
    .empty    (fifo_empty),
    .full     (fifo_full_unused),
    .count    (q_count)
  );

  // Outputs read as zero whenever nothing is queued, including throughout reset.
  assign rsp_valid = !fifo_empty;
  assign rsp_instr = rsp_valid ? head_rsp.instr : 32'h0;
  assign rsp_pc    = rsp_valid ? head_rsp.pc    : 32'h0;
  assign rsp_err   = rsp_valid ? head_rsp.err   : 1'b0;

endmodule
